cache_mem_burst_bridge: RTL and testbench
=========================================

Name: cache_mem_burst_bridge

Overview:
- Successor bridge between the unified cache's to-mem/from-mem packet interface and a burst memory port. Replaces the single-transaction, pulse-driven bridge.
- Adds a request queue, posted writes, and multiple in-order outstanding reads.
- Adds beat serialisation and deserialisation for any block/bus width ratio.
- Sits between unified_cache and the memory-side master (AXI shim or test memory).

Parameters:
- ADDR_WIDTH, 32, request address width.
- BLOCK_SIZE_IN_BITS, 128, cache block width; must be a multiple of MEM_DATA_WIDTH.
- MEM_DATA_WIDTH, 32, memory beat width; must be a multiple of 8.
- PORT_ID_WIDTH, 2, cache port-number field width.
- REQ_QUEUE_DEPTH, 4, request FIFO entries; power of 2, ≥2.
- MAX_OUTSTANDING_READS, 2, read commands issued without data returned; ≥1.
- BEATS (derived), BLOCK_SIZE_IN_BITS/MEM_DATA_WIDTH, beats per block.

Ports:
- clk_in  in  1  clock
- reset_in  in  1  async active-high reset
- req_valid_in  in  1  cache request valid (held until ack)
- req_is_write_in  in  1  1 = write-back, 0 = fill
- req_addr_in  in  ADDR_WIDTH  request address
- req_data_in  in  BLOCK_SIZE_IN_BITS  write data
- req_byte_mask_in  in  BLOCK_SIZE_IN_BITS/8  write byte enables
- req_port_in  in  PORT_ID_WIDTH  originating port
- req_ack_out  out  1  one-cycle accept pulse
- resp_valid_out  out  1  fill data valid
- resp_addr_out  out  ADDR_WIDTH  fill block address
- resp_data_out  out  BLOCK_SIZE_IN_BITS  fill data
- resp_port_out  out  PORT_ID_WIDTH  fill port
- resp_ack_in  in  1  cache consumed fill
- mem_cmd_valid_out / mem_cmd_ready_in  out/in  1  command handshake
- mem_cmd_is_write_out  out  1  command direction
- mem_cmd_addr_out  out  ADDR_WIDTH  block-aligned command address
- mem_cmd_len_out  out  8  BEATS-1
- mem_wdata_valid_out / mem_wdata_ready_in  out/in  1  write beat handshake
- mem_wdata_out  out  MEM_DATA_WIDTH  write beat data
- mem_wstrb_out  out  MEM_DATA_WIDTH/8  write beat strobes
- mem_wlast_out  out  1  final write beat
- mem_bvalid_in / mem_bready_out  in/out  1  write response handshake
- mem_rvalid_in / mem_rready_out  in/out  1  read beat handshake
- mem_rdata_in  in  MEM_DATA_WIDTH  read beat data
- mem_rlast_in  in  1  final read beat
- idle_out  out  1  queue empty, FSM IDLE, no pending reads, no resp held
- err_out  out  1  sticky rlast-mismatch flag

Behaviour:
- Reset (async): all outputs 0 except idle_out=1. FIFO, pending-read FIFO, beat counters and FSM are cleared. In-flight requests are discarded.
- Accept rule:
  - Enqueue when req_valid_in & ~req_ack_out & ~queue_full.
  - req_ack_out is registered: high the cycle after enqueue, for exactly one cycle.
  - The cycle with req_ack_out high never enqueues, so a held request is not double-accepted.
  - Writes are posted: acked on enqueue.
- Address: mem_cmd_addr_out = req_addr with low log2(BLOCK_SIZE_IN_BITS/8) bits zeroed.
- Issue FSM:
  - IDLE:
    - Queue head is a read and pending_reads < MAX_OUTSTANDING_READS → CMD.
    - Queue head is a write and pending_reads == 0 and no resp held → CMD. This keeps write-after-read ordering.
  - CMD: mem_cmd_valid_out=1 with head fields. On mem_cmd_ready_in:
    - Read → push {addr, port} to pending FIFO, pop queue, IDLE.
    - Write → latch block into shift register, pop queue, WDATA.
  - WDATA:
    - Beat i = data[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH], beat 0 first; strobes are the matching mask slice.
    - mem_wlast_out=1 on beat BEATS-1.
    - Beat index advances only on valid&ready. After the last beat → WRESP.
  - WRESP: mem_bready_out=1. On mem_bvalid_in → IDLE.
- Read return:
  - mem_rready_out = pending_reads>0 & ~resp_valid_out.
  - Beat k is stored at slice k.
  - On beat BEATS-1: present resp_valid_out with data plus the pending FIFO head's addr/port, then pop the pending FIFO.
  - Hold until resp_ack_in, then drop resp_valid_out the next cycle.
  - mem_rlast_in must equal (k==BEATS-1); any mismatch sets err_out, which stays set until reset. Data is still returned by count.
- Simultaneous events:
  - Pending push (CMD) and pop (final beat) in the same cycle leave the count unchanged.
  - Enqueue and dequeue in the same cycle are allowed when not full; full is evaluated before the pop.
- BEATS==1: the single beat is both first and last; wlast is always 1 and rlast is expected 1.

Test Plan:
- Read @0x1000, port 2; memory returns 4 beats 0x11..0x44 after 3 cycles → resp_data=0x00000044_00000033_00000022_00000011, resp_addr=0x1000, resp_port=2, mem_cmd_len_out=3.
- Write @0x2004 (aligned to 0x2000), mask 0xFFF0, wdata_ready toggling each cycle → 4 wdata beats, wstrb 0x0 then 0xF,0xF,0xF; wlast only on beat 3; FSM waits for bvalid.
- Three back-to-back reads with MAX_OUTSTANDING_READS=2 → third command withheld until first fill completes; fills return in issue order with correct ports.
- Read then write queued → write command not issued until read fill is acked; resp_ack_in delayed 5 cycles → resp held stable, rready=0.
- Five requests held with memory stalled → exactly 4 acks, 5th acked one cycle after first dequeue; no duplicate ack.
- rlast asserted on beat 1 → err_out=1 sticky; reset mid-WDATA → all outputs zero, idle_out=1 next cycle.

Source files
------------

// File: rtl/cache_mem_burst_bridge.sv
// Cache-to-burst-memory bridge: request queue, posted writes,
// in-order outstanding reads, beat (de)serialisation.
module cache_mem_burst_bridge #(
  parameter int ADDR_WIDTH            = 32,
  parameter int BLOCK_SIZE_IN_BITS    = 128,
  parameter int MEM_DATA_WIDTH        = 32,
  parameter int PORT_ID_WIDTH         = 2,
  parameter int REQ_QUEUE_DEPTH       = 4,
  parameter int MAX_OUTSTANDING_READS = 2
) (
  input  logic                            clk_in,
  input  logic                            reset_in,
  input  logic                            req_valid_in,
  input  logic                            req_is_write_in,
  input  logic [ADDR_WIDTH-1:0]           req_addr_in,
  input  logic [BLOCK_SIZE_IN_BITS-1:0]   req_data_in,
  input  logic [BLOCK_SIZE_IN_BITS/8-1:0] req_byte_mask_in,
  input  logic [PORT_ID_WIDTH-1:0]        req_port_in,
  output logic                            req_ack_out,
  output logic                            resp_valid_out,
  output logic [ADDR_WIDTH-1:0]           resp_addr_out,
  output logic [BLOCK_SIZE_IN_BITS-1:0]   resp_data_out,
  output logic [PORT_ID_WIDTH-1:0]        resp_port_out,
  input  logic                            resp_ack_in,
  output logic                            mem_cmd_valid_out,
  input  logic                            mem_cmd_ready_in,
  output logic                            mem_cmd_is_write_out,
  output logic [ADDR_WIDTH-1:0]           mem_cmd_addr_out,
  output logic [7:0]                      mem_cmd_len_out,
  output logic                            mem_wdata_valid_out,
  input  logic                            mem_wdata_ready_in,
  output logic [MEM_DATA_WIDTH-1:0]       mem_wdata_out,
  output logic [MEM_DATA_WIDTH/8-1:0]     mem_wstrb_out,
  output logic                            mem_wlast_out,
  input  logic                            mem_bvalid_in,
  output logic                            mem_bready_out,
  input  logic                            mem_rvalid_in,
  output logic                            mem_rready_out,
  input  logic [MEM_DATA_WIDTH-1:0]       mem_rdata_in,
  input  logic                            mem_rlast_in,
  output logic                            idle_out,
  output logic                            err_out
);
  localparam int BEATS  = BLOCK_SIZE_IN_BITS / MEM_DATA_WIDTH;
  localparam int MASK_W = BLOCK_SIZE_IN_BITS / 8;
  localparam int STRB_W = MEM_DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(MASK_W);
  localparam int QW     = $clog2(REQ_QUEUE_DEPTH);
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NP     = MAX_OUTSTANDING_READS;
  localparam int PW     = (NP > 1) ? $clog2(NP) : 1;
  localparam int PCW    = $clog2(NP + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'((1 << OFFS) - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef struct packed {
    logic                          w;
    logic [ADDR_WIDTH-1:0]         addr;
    logic [BLOCK_SIZE_IN_BITS-1:0] data;
    logic [MASK_W-1:0]             mask;
    logic [PORT_ID_WIDTH-1:0]      port;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_WRESP} state_t;

  state_t state_q, state_d;
  req_t   q_mem [REQ_QUEUE_DEPTH];
  req_t   head, req_new;
  logic [QW:0] qwp_q, qrp_q, q_cnt;
  logic q_full, q_empty, enq, pop, req_ack_q;

  logic [ADDR_WIDTH-1:0]    p_addr [NP];
  logic [PORT_ID_WIDTH-1:0] p_port [NP];
  logic [PW-1:0]  pwp_q, prp_q;
  logic [PCW-1:0] pcnt_q;
  logic push_p, pop_p;

  logic [BLOCK_SIZE_IN_BITS-1:0] wsh_q;
  logic [MASK_W-1:0] wmk_q;
  logic [BW-1:0]     wbeat_q;
  logic w_hs, wlast;

  logic [BLOCK_SIZE_IN_BITS-1:0] rbuf_q, rbuf_d, resp_data_q;
  logic [BW-1:0] rbeat_q;
  logic r_hs, rlast_exp, rready;
  logic resp_valid_q, err_q;
  logic [ADDR_WIDTH-1:0]    resp_addr_q;
  logic [PORT_ID_WIDTH-1:0] resp_port_q;

  logic cmd_valid, wvalid, bready;

  function automatic logic [PW-1:0] pinc(input logic [PW-1:0] p);
    return (p == PW'(NP - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_new = '{w: req_is_write_in, addr: req_addr_in,
                     data: req_data_in, mask: req_byte_mask_in,
                     port: req_port_in};
  assign q_cnt   = qwp_q - qrp_q;
  assign q_full  = q_cnt == (QW+1)'(REQ_QUEUE_DEPTH);
  assign q_empty = q_cnt == '0;
  assign head    = q_mem[qrp_q[QW-1:0]];
  assign enq     = req_valid_in & ~req_ack_q & ~q_full;
  assign pop     = cmd_valid & mem_cmd_ready_in;
  assign push_p  = pop & ~head.w;
  assign rready  = (pcnt_q != '0) & ~resp_valid_q;
  assign r_hs    = mem_rvalid_in & rready;
  assign rlast_exp = rbeat_q == LAST_BEAT;
  assign pop_p   = r_hs & rlast_exp;
  assign w_hs    = wvalid & mem_wdata_ready_in;
  assign wlast   = wbeat_q == LAST_BEAT;

  // request queue pointers and registered accept pulse
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      qwp_q     <= '0;
      qrp_q     <= '0;
      req_ack_q <= 1'b0;
    end else begin
      req_ack_q <= enq;
      if (enq) qwp_q <= qwp_q + 1'b1;
      if (pop) qrp_q <= qrp_q + 1'b1;
    end
  end

  // request queue storage
  always_ff @(posedge clk_in) begin
    if (enq) q_mem[qwp_q[QW-1:0]] <= req_new;
  end

  // pending-read FIFO pointers and occupancy
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pwp_q  <= '0;
      prp_q  <= '0;
      pcnt_q <= '0;
    end else begin
      if (push_p) pwp_q <= pinc(pwp_q);
      if (pop_p)  prp_q <= pinc(prp_q);
      unique case ({push_p, pop_p})
        2'b10:   pcnt_q <= pcnt_q + 1'b1;
        2'b01:   pcnt_q <= pcnt_q - 1'b1;
        default: pcnt_q <= pcnt_q;
      endcase
    end
  end

  // pending-read FIFO storage (block-aligned address, port)
  always_ff @(posedge clk_in) begin
    if (push_p) begin
      p_addr[pwp_q] <= head.addr & ALIGN;
      p_port[pwp_q] <= head.port;
    end
  end

  // issue FSM state register
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // issue FSM next state; writes wait for all reads to drain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!q_empty) begin
          if (head.w) begin
            if (pcnt_q == '0 && !resp_valid_q) state_d = S_CMD;
          end else if (pcnt_q < PCW'(NP)) begin
            state_d = S_CMD;
          end
        end
      end
      S_CMD:   if (mem_cmd_ready_in) state_d = head.w ? S_WDATA : S_IDLE;
      S_WDATA: if (w_hs && wlast) state_d = S_WRESP;
      S_WRESP: if (mem_bvalid_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // issue FSM outputs
  always_comb begin
    cmd_valid = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    unique case (state_q)
      S_CMD:   cmd_valid = 1'b1;
      S_WDATA: wvalid    = 1'b1;
      S_WRESP: bready    = 1'b1;
      default: ;
    endcase
  end

  // write block serialiser: beat 0 sits in the low slice
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wsh_q   <= '0;
      wmk_q   <= '0;
      wbeat_q <= '0;
    end else if (pop && head.w) begin
      wsh_q   <= head.data;
      wmk_q   <= head.mask;
      wbeat_q <= '0;
    end else if (w_hs) begin
      wsh_q   <= wsh_q >> MEM_DATA_WIDTH;
      wmk_q   <= wmk_q >> STRB_W;
      wbeat_q <= wlast ? '0 : wbeat_q + 1'b1;
    end
  end

  // merge the incoming read beat into its slice
  always_comb begin
    rbuf_d = rbuf_q;
    for (int i = 0; i < BEATS; i++) begin
      if (rbeat_q == BW'(i))
        rbuf_d[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rdata_in;
    end
  end

  // read deserialiser, fill response hold and sticky rlast error
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rbuf_q       <= '0;
      rbeat_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_addr_q  <= '0;
      resp_port_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      if (r_hs) begin
        rbuf_q  <= rbuf_d;
        rbeat_q <= rlast_exp ? '0 : rbeat_q + 1'b1;
        if (mem_rlast_in != rlast_exp) err_q <= 1'b1;
        if (rlast_exp) begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= rbuf_d;
          resp_addr_q  <= p_addr[prp_q];
          resp_port_q  <= p_port[prp_q];
        end
      end else if (resp_valid_q && resp_ack_in) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign req_ack_out          = req_ack_q;
  assign resp_valid_out       = resp_valid_q;
  assign resp_addr_out        = resp_addr_q;
  assign resp_data_out        = resp_data_q;
  assign resp_port_out        = resp_port_q;
  assign mem_cmd_valid_out    = cmd_valid;
  assign mem_cmd_is_write_out = cmd_valid & head.w;
  assign mem_cmd_addr_out     = cmd_valid ? (head.addr & ALIGN) : '0;
  assign mem_cmd_len_out      = cmd_valid ? 8'(BEATS - 1) : 8'd0;
  assign mem_wdata_valid_out  = wvalid;
  assign mem_wdata_out        = wsh_q[MEM_DATA_WIDTH-1:0];
  assign mem_wstrb_out        = wmk_q[STRB_W-1:0];
  assign mem_wlast_out        = wvalid & wlast;
  assign mem_bready_out       = bready;
  assign mem_rready_out       = rready;
  assign idle_out = q_empty & (state_q == S_IDLE) &
                    (pcnt_q == '0) & ~resp_valid_q;
  assign err_out  = err_q;
endmodule

// File: tb/tb_cache_mem_burst_bridge.sv
// Directed bench for cache_mem_burst_bridge: read table plus
// hand sequences for writes, ordering, backpressure, errors, reset.
module tb_cache_mem_burst_bridge;
  logic         clk_in = 1'b0;
  logic         reset_in;
  logic         req_valid_in, req_is_write_in;
  logic [31:0]  req_addr_in;
  logic [127:0] req_data_in;
  logic [15:0]  req_byte_mask_in;
  logic [1:0]   req_port_in;
  logic         req_ack_out, resp_valid_out;
  logic [31:0]  resp_addr_out;
  logic [127:0] resp_data_out;
  logic [1:0]   resp_port_out;
  logic         resp_ack_in;
  logic         mem_cmd_valid_out, mem_cmd_ready_in, mem_cmd_is_write_out;
  logic [31:0]  mem_cmd_addr_out;
  logic [7:0]   mem_cmd_len_out;
  logic         mem_wdata_valid_out, mem_wdata_ready_in;
  logic [31:0]  mem_wdata_out;
  logic [3:0]   mem_wstrb_out;
  logic         mem_wlast_out, mem_bvalid_in, mem_bready_out;
  logic         mem_rvalid_in, mem_rready_out;
  logic [31:0]  mem_rdata_in;
  logic         mem_rlast_in, idle_out, err_out;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  cache_mem_burst_bridge dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .req_valid_in(req_valid_in), .req_is_write_in(req_is_write_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in),
    .req_byte_mask_in(req_byte_mask_in), .req_port_in(req_port_in),
    .req_ack_out(req_ack_out), .resp_valid_out(resp_valid_out),
    .resp_addr_out(resp_addr_out), .resp_data_out(resp_data_out),
    .resp_port_out(resp_port_out), .resp_ack_in(resp_ack_in),
    .mem_cmd_valid_out(mem_cmd_valid_out),
    .mem_cmd_ready_in(mem_cmd_ready_in),
    .mem_cmd_is_write_out(mem_cmd_is_write_out),
    .mem_cmd_addr_out(mem_cmd_addr_out),
    .mem_cmd_len_out(mem_cmd_len_out),
    .mem_wdata_valid_out(mem_wdata_valid_out),
    .mem_wdata_ready_in(mem_wdata_ready_in),
    .mem_wdata_out(mem_wdata_out), .mem_wstrb_out(mem_wstrb_out),
    .mem_wlast_out(mem_wlast_out), .mem_bvalid_in(mem_bvalid_in),
    .mem_bready_out(mem_bready_out), .mem_rvalid_in(mem_rvalid_in),
    .mem_rready_out(mem_rready_out), .mem_rdata_in(mem_rdata_in),
    .mem_rlast_in(mem_rlast_in), .idle_out(idle_out), .err_out(err_out)
  );

  typedef struct {
    logic [31:0]       addr;
    logic [1:0]        port;
    logic [3:0][31:0]  beat;
    logic [31:0]       exp_addr;
    logic [127:0]      exp_data;
  } rd_vec_t;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [31:0] a,
                        input logic [127:0] d, input logic [15:0] m,
                        input logic [1:0] p, input string nm);
    int n = 0;
    req_is_write_in = w; req_addr_in = a; req_data_in = d;
    req_byte_mask_in = m; req_port_in = p; req_valid_in = 1'b1;
    do begin tick(); n++; end while (!req_ack_out && n < 50);
    req_valid_in = 1'b0;
    chk({nm, "_ack"}, req_ack_out, 1'b1);
  endtask

  task automatic wait_cmd(input logic w, input logic [31:0] a,
                          input string nm);
    int n = 0;
    while (!mem_cmd_valid_out && n < 50) begin tick(); n++; end
    chk({nm, "_cmdv"}, mem_cmd_valid_out, 1'b1);
    chk({nm, "_cmdw"}, mem_cmd_is_write_out, w);
    chk({nm, "_cmda"}, mem_cmd_addr_out, a);
    chk({nm, "_len"}, mem_cmd_len_out, 8'd3);
    mem_cmd_ready_in = 1'b1;
    tick();
    mem_cmd_ready_in = 1'b0;
  endtask

  task automatic send_beats(input logic [3:0][31:0] b,
                            input logic [3:0] lastpat, input string nm);
    int n;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid_in = 1'b1;
      mem_rdata_in  = b[k];
      mem_rlast_in  = lastpat[k];
      n = 0;
      while (!mem_rready_out && n < 50) begin tick(); n++; end
      if (!mem_rready_out) chk({nm, "_rready_to"}, mem_rready_out, 1'b1);
      tick();
    end
    mem_rvalid_in = 1'b0;
    mem_rlast_in  = 1'b0;
  endtask

  task automatic get_resp(input logic [127:0] d, input logic [31:0] a,
                          input logic [1:0] p, input int dly,
                          input string nm);
    int n = 0;
    while (!resp_valid_out && n < 50) begin tick(); n++; end
    chk({nm, "_rv"}, resp_valid_out, 1'b1);
    chk({nm, "_rdata"}, resp_data_out, d);
    chk({nm, "_raddr"}, resp_addr_out, a);
    chk({nm, "_rport"}, resp_port_out, p);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk({nm, "_hold_v"}, resp_valid_out, 1'b1);
      chk({nm, "_hold_d"}, resp_data_out, d);
      chk({nm, "_hold_rr"}, mem_rready_out, 1'b0);
      chk({nm, "_hold_cmd"}, mem_cmd_valid_out, 1'b0);
    end
    resp_ack_in = 1'b1;
    tick();
    resp_ack_in = 1'b0;
    chk({nm, "_rv_drop"}, resp_valid_out, 1'b0);
  endtask

  task automatic drain_write(input string nm);
    int nb = 0;
    int n = 0;
    mem_wdata_ready_in = 1'b1;
    while (nb < 4 && n < 50) begin
      if (mem_wdata_valid_out) nb++;
      tick(); n++;
    end
    mem_wdata_ready_in = 1'b0;
    chk({nm, "_nbeats"}, nb, 4);
    mem_bvalid_in = 1'b1;
    tick();
    mem_bvalid_in = 1'b0;
    chk({nm, "_idle"}, idle_out, 1'b1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ack"}, req_ack_out, 1'b0);
    chk({nm, "_rv"}, resp_valid_out, 1'b0);
    chk({nm, "_rdata"}, resp_data_out, 128'h0);
    chk({nm, "_cmdv"}, mem_cmd_valid_out, 1'b0);
    chk({nm, "_cmda"}, mem_cmd_addr_out, 32'h0);
    chk({nm, "_len"}, mem_cmd_len_out, 8'h0);
    chk({nm, "_wv"}, mem_wdata_valid_out, 1'b0);
    chk({nm, "_wd"}, mem_wdata_out, 32'h0);
    chk({nm, "_ws"}, mem_wstrb_out, 4'h0);
    chk({nm, "_wl"}, mem_wlast_out, 1'b0);
    chk({nm, "_br"}, mem_bready_out, 1'b0);
    chk({nm, "_rr"}, mem_rready_out, 1'b0);
    chk({nm, "_err"}, err_out, 1'b0);
    chk({nm, "_idle"}, idle_out, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rd_vec_t vec [3];
    logic [3:0][31:0] wexp;
    logic [3:0][3:0]  sexp;
    int nb, n, idx, first_ack;

    vec[0] = '{32'h0000_1000, 2'd2,
               {32'h44, 32'h33, 32'h22, 32'h11}, 32'h0000_1000,
               128'h00000044_00000033_00000022_00000011};
    vec[1] = '{32'h0000_300C, 2'd1,
               {32'hCAFEF00D, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF},
               32'h0000_3000,
               128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF};
    vec[2] = '{32'hABCD_EF1F, 2'd3,
               {32'h4, 32'h3, 32'h2, 32'h1}, 32'hABCD_EF10,
               128'h00000004_00000003_00000002_00000001};

    reset_in = 1'b1;
    req_valid_in = 0; req_is_write_in = 0; req_addr_in = 0;
    req_data_in = 0; req_byte_mask_in = 0; req_port_in = 0;
    resp_ack_in = 0; mem_cmd_ready_in = 0; mem_wdata_ready_in = 0;
    mem_bvalid_in = 0; mem_rvalid_in = 0; mem_rdata_in = 0;
    mem_rlast_in = 0;
    tick(); tick();
    chk_reset("rst0");
    reset_in = 1'b0;
    tick();

    // table of single reads, 3-cycle memory latency
    for (int v = 0; v < 3; v++) begin
      do_req(1'b0, vec[v].addr, 128'h0, 16'h0, vec[v].port, "rd");
      wait_cmd(1'b0, vec[v].exp_addr, "rd");
      repeat (3) tick();
      send_beats(vec[v].beat, 4'b1000, "rd");
      get_resp(vec[v].exp_data, vec[v].exp_addr, vec[v].port, 0, "rd");
      chk("rd_idle", idle_out, 1'b1);
    end

    // write with partial mask and toggling wdata_ready
    do_req(1'b1, 32'h2004, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
           16'hFFF0, 2'd0, "wr");
    wait_cmd(1'b1, 32'h2000, "wr");
    wexp = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    sexp = {4'hF, 4'hF, 4'hF, 4'h0};
    nb = 0; n = 0;
    while (nb < 4 && n < 60) begin
      mem_wdata_ready_in = ~mem_wdata_ready_in;
      if (mem_wdata_valid_out && mem_wdata_ready_in) begin
        chk("wr_data", mem_wdata_out, wexp[nb]);
        chk("wr_strb", mem_wstrb_out, sexp[nb]);
        chk("wr_last", mem_wlast_out, nb == 3);
        nb++;
      end
      tick(); n++;
    end
    mem_wdata_ready_in = 1'b0;
    chk("wr_nbeats", nb, 4);
    repeat (3) tick();
    chk("wr_bready", mem_bready_out, 1'b1);
    chk("wr_busy", idle_out, 1'b0);
    mem_bvalid_in = 1'b1;
    tick();
    mem_bvalid_in = 1'b0;
    chk("wr_bready_drop", mem_bready_out, 1'b0);
    chk("wr_idle", idle_out, 1'b1);

    // three reads, only two outstanding
    do_req(1'b0, 32'h7000, 128'h0, 16'h0, 2'd1, "or");
    do_req(1'b0, 32'h7100, 128'h0, 16'h0, 2'd2, "or");
    do_req(1'b0, 32'h7200, 128'h0, 16'h0, 2'd3, "or");
    wait_cmd(1'b0, 32'h7000, "or1");
    wait_cmd(1'b0, 32'h7100, "or2");
    repeat (5) tick();
    chk("or_withheld", mem_cmd_valid_out, 1'b0);
    send_beats({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b1000, "or1");
    get_resp(128'h000000A3_000000A2_000000A1_000000A0, 32'h7000,
             2'd1, 0, "or1");
    wait_cmd(1'b0, 32'h7200, "or3");
    send_beats({32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b1000, "or2");
    get_resp(128'h000000B3_000000B2_000000B1_000000B0, 32'h7100,
             2'd2, 0, "or2");
    send_beats({32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4'b1000, "or3");
    get_resp(128'h000000C3_000000C2_000000C1_000000C0, 32'h7200,
             2'd3, 0, "or3");
    chk("or_idle", idle_out, 1'b1);

    // write queued behind a read waits for the fill ack
    do_req(1'b0, 32'h4000, 128'h0, 16'h0, 2'd1, "rw");
    do_req(1'b1, 32'h5000, 128'h1, 16'hFFFF, 2'd0, "rw");
    wait_cmd(1'b0, 32'h4000, "rw_r");
    send_beats({32'hD3, 32'hD2, 32'hD1, 32'hD0}, 4'b1000, "rw");
    get_resp(128'h000000D3_000000D2_000000D1_000000D0, 32'h4000,
             2'd1, 5, "rw");
    wait_cmd(1'b1, 32'h5000, "rw_w");
    drain_write("rw");

    // five held requests against a stalled command port
    idx = 0;
    req_is_write_in = 1'b0; req_port_in = 2'd0;
    req_addr_in = 32'h8000; req_valid_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (req_ack_out) begin
        idx++;
        req_addr_in = 32'h8000 + 32'(idx) * 32'h40;
      end
    end
    chk("q_acks4", idx, 4);
    chk("q_cmd_stall", mem_cmd_valid_out, 1'b1);
    mem_cmd_ready_in = 1'b1;
    first_ack = -1;
    for (int c = 0; c < 10; c++) begin
      tick();
      mem_cmd_ready_in = 1'b0;
      if (req_ack_out) begin
        if (first_ack < 0) first_ack = c;
        idx++;
        req_valid_in = 1'b0;
      end
    end
    chk("q_acks5", idx, 5);
    chk("q_ack5_time", first_ack, 1);
    reset_in = 1'b1;
    #1;
    chk_reset("rst1");
    tick();
    reset_in = 1'b0;
    tick();

    // early rlast sets sticky error, data still returned by count
    do_req(1'b0, 32'h6000, 128'h0, 16'h0, 2'd1, "er");
    wait_cmd(1'b0, 32'h6000, "er");
    send_beats({32'hE3, 32'hE2, 32'hE1, 32'hE0}, 4'b0010, "er");
    chk("er_err", err_out, 1'b1);
    get_resp(128'h000000E3_000000E2_000000E1_000000E0, 32'h6000,
             2'd1, 0, "er");
    repeat (5) tick();
    chk("er_sticky", err_out, 1'b1);

    // async reset in the middle of a write burst
    do_req(1'b1, 32'h9000, 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978,
           16'hFFFF, 2'd2, "rm");
    wait_cmd(1'b1, 32'h9000, "rm");
    mem_wdata_ready_in = 1'b1;
    tick();
    mem_wdata_ready_in = 1'b0;
    chk("rm_in_wdata", mem_wdata_valid_out, 1'b1);
    chk("rm_beat1", mem_wdata_out, 32'h0F1E2D3C);
    #2;
    reset_in = 1'b1;
    #1;
    chk_reset("rst2");
    tick();
    chk("rst2_idle_next", idle_out, 1'b1);
    reset_in = 1'b0;
    tick();
    chk("post_rst_idle", idle_out, 1'b1);
    chk("post_rst_err", err_out, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
